// File: rtl/ifu_fetch_if.sv
// Fetch unit signal bundle: core-side instruction handshake and memory read port.
// master is the fetch unit's view; slave is the core/memory side.
interface ifu_fetch_if;
  logic [31:0] next_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  modport master (
    input  next_pc, inst_ready, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst, inst_pc, inst_valid, fault, mem_req_valid, mem_addr
  );

  modport slave (
    output next_pc, inst_ready, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst, inst_pc, inst_valid, fault, mem_req_valid, mem_addr
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one word read per instruction, REQ -> WAIT -> HOLD, no pipelining.
// The core supplies every next PC; this block only checks alignment and bounds the wait.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] RESET_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic [1:0]      fault_q, fault_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      inst_q    <= RESET_INST;
      inst_pc_q <= RESET_PC;
      fault_q   <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StReq: begin
        if (bus.mem_req_ready) state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the last allowed cycle still wins over the timeout.
        if (bus.mem_rsp_valid) begin
          inst_d    = bus.mem_rsp_data;
          inst_pc_d = pc_q;
          fault_d   = bus.mem_rsp_err ? 2'd2 : 2'd0;
          state_d   = StHold;
        end else if (cnt_q == CntMax) begin
          inst_d  = RESET_INST;
          fault_d = 2'd3;
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.inst_ready) begin
          pc_d  = bus.next_pc;
          cnt_d = '0;
          // Misaligned target is reported without touching memory.
          if (bus.next_pc[1:0] != 2'b00) begin
            inst_d    = RESET_INST;
            inst_pc_d = bus.next_pc;
            fault_d   = 2'd1;
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StReq;
    endcase
  end

  assign bus.mem_req_valid = (state_q == StReq) & ~rst;
  assign bus.inst_valid    = (state_q == StHold) & ~rst;
  assign bus.mem_addr      = {pc_q[31:2], 2'b00};
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a transaction-level model of the core and memory
// predicts, cycle by cycle, when a request or an instruction must be visible and its contents.
module tb_ifu_fetch;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] RINST = 32'h0000_0013;
  localparam int          Tmo   = 8;
  localparam int          NCyc  = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC  (RPC),
    .RESET_INST(RINST),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of what the core should see and what memory owes
  logic        want_req, want_hold, just_rst, first;
  logic [31:0] pc_m, e_inst, e_pc;
  logic [1:0]  e_fault;
  logic        busy, p_err;
  int          wcnt, dly;
  logic [31:0] p_data, p_addr;

  task automatic model_reset();
    want_req  = 1'b1;
    want_hold = 1'b0;
    pc_m      = RPC;
    e_inst    = RINST;
    e_pc      = RPC;
    e_fault   = 2'd0;
    busy      = 1'b0;
    just_rst  = 1'b1;
  endtask

  logic        req_next, hold_next, rdy, rsp_v, rsp_e, core_rdy;
  logic [31:0] rsp_d, npc;

  initial begin
    rst                = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.mem_rsp_err    = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.next_pc        = RPC;
    first              = 1'b1;
    model_reset();
    #1;
    check("req_valid_in_reset", 32'(bus.mem_req_valid), 32'd0);
    @(posedge clk);

    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("req_valid", 32'(bus.mem_req_valid), 32'(want_req));
      check("inst_valid", 32'(bus.inst_valid), 32'(want_hold));
      if (want_req) check("mem_addr", bus.mem_addr, pc_m);
      if (want_hold || just_rst) begin
        check("inst", bus.inst, e_inst);
        check("inst_pc", bus.inst_pc, e_pc);
        check("fault", 32'(bus.fault), 32'(e_fault));
      end
      just_rst = 1'b0;

      if ($urandom_range(0, 99) == 0) begin
        rst               = 1'b1;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.inst_ready    = 1'b0;
        model_reset();
        #1;
        check("req_valid_in_reset", 32'(bus.mem_req_valid), 32'd0);
        continue;
      end

      req_next  = want_req;
      hold_next = want_hold;

      // Memory response side
      rsp_v = 1'b0;
      rsp_d = $urandom;
      rsp_e = 1'($urandom);
      if (busy) begin
        if (wcnt == dly) begin
          rsp_v = 1'b1;
          rsp_d = p_data;
          rsp_e = p_err;
        end
        if (dly < Tmo && wcnt == dly) begin
          hold_next = 1'b1;
          e_inst    = p_data;
          e_pc      = p_addr;
          e_fault   = p_err ? 2'd2 : 2'd0;
        end else if (dly >= Tmo && wcnt == Tmo - 1) begin
          hold_next = 1'b1;
          e_inst    = RINST;
          e_fault   = 2'd3;
        end
        wcnt++;
        if (wcnt > dly || wcnt > Tmo) busy = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        rsp_v = 1'b1;  // stray response with nothing outstanding
      end

      // Memory request side
      rdy = first ? 1'b1 : ($urandom_range(0, 99) < 55);
      if (want_req && rdy) begin
        req_next = 1'b0;
        busy     = 1'b1;
        wcnt     = 0;
        p_addr   = pc_m;
        p_data   = $urandom;
        p_err    = ($urandom_range(0, 99) < 15);
        case ($urandom_range(0, 19))
          0:       dly = Tmo;        // late response, lands after timeout
          1:       dly = Tmo + 50;   // never answers
          default: dly = $urandom_range(0, Tmo - 1);
        endcase
        if (first) begin
          dly    = 0;
          p_data = 32'h0010_0093;
          p_err  = 1'b0;
          first  = 1'b0;
        end
      end

      // Core side
      core_rdy = ($urandom_range(0, 99) < 50);
      npc      = RPC + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 99) < 12) npc[1:0] = 2'($urandom_range(1, 3));
      if (want_hold && core_rdy) begin
        pc_m = npc;
        if (npc[1:0] != 2'b00) begin
          e_inst  = RINST;
          e_pc    = npc;
          e_fault = 2'd1;
        end else begin
          hold_next = 1'b0;
          req_next  = 1'b1;
        end
      end

      bus.mem_req_ready = rdy;
      bus.mem_rsp_valid = rsp_v;
      bus.mem_rsp_data  = rsp_d;
      bus.mem_rsp_err   = rsp_e;
      bus.inst_ready    = core_rdy;
      bus.next_pc       = npc;
      want_req          = req_next;
      want_hold         = hold_next;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
